// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between the CPU sequencer and a DMA requester; CPU wins ties
// unless DMA has been passed over STARVE_LIMIT times. All outputs are registered.
module mem_bus_arbiter #(
  parameter int WIDTH        = 16,
  parameter int WAIT_CYCLES  = 1,
  parameter int STARVE_LIMIT = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_rw,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic             cpu_ack,
  output logic [WIDTH-1:0] cpu_rdata,
  input  logic             dma_req,
  input  logic             dma_rw,
  input  logic [WIDTH-1:0] dma_addr,
  input  logic [WIDTH-1:0] dma_wdata,
  output logic             dma_ack,
  output logic [WIDTH-1:0] dma_rdata,
  output logic             mem_vma,
  output logic             mem_rw,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [3:0] WAIT_LOAD  = 4'(WAIT_CYCLES);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [1:0] state;
  logic [3:0] waitCnt;
  logic [3:0] starveCnt;
  logic       grantDma;
  logic       anyReq;
  logic       pickDma;

  // DMA wins only when alone or when it has been starved long enough.
  always_comb begin
    anyReq  = cpu_req | dma_req;
    pickDma = dma_req & (~cpu_req | (starveCnt == STARVE_MAX));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      waitCnt   <= 4'd0;
      starveCnt <= 4'd0;
      grantDma  <= 1'b0;
      mem_vma   <= 1'b0;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
      busy      <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (anyReq) begin
            grantDma  <= pickDma;
            mem_vma   <= 1'b1;
            mem_rw    <= pickDma ? dma_rw    : cpu_rw;
            mem_addr  <= pickDma ? dma_addr  : cpu_addr;
            mem_wdata <= pickDma ? dma_wdata : cpu_wdata;
            waitCnt   <= WAIT_LOAD;
            state     <= ACCESS;
            busy      <= 1'b1;
            if (!pickDma && dma_req) begin
              if (starveCnt != STARVE_MAX) starveCnt <= starveCnt + 4'd1;
            end else begin
              starveCnt <= 4'd0;
            end
          end
        end
        ACCESS: begin
          if (waitCnt != 4'd0) begin
            waitCnt <= waitCnt - 4'd1;
          end else begin
            // Last access cycle: read data is valid on mem_rdata now.
            mem_vma <= 1'b0;
            state   <= DONE;
            if (grantDma) begin
              dma_ack <= 1'b1;
              if (!mem_rw) dma_rdata <= mem_rdata;
            end else begin
              cpu_ack <= 1'b1;
              if (!mem_rw) cpu_rdata <= mem_rdata;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          mem_vma <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: per-requester expected queues popped on ack, plus a
// second instance built with WAIT_CYCLES=3.
module tb_mem_bus_arbiter;

  localparam int WAIT_A = 1;
  localparam int WAIT_B = 3;

  typedef struct packed {
    logic        rw;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } txn_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        cpuReq = 0, cpuRw = 0, cpuAck;
  logic [15:0] cpuAddr = 0, cpuWdata = 0, cpuRdata;
  logic        dmaReq = 0, dmaRw = 0, dmaAck;
  logic [15:0] dmaAddr = 0, dmaWdata = 0, dmaRdata;
  logic        memVma, memRw, busy;
  logic [15:0] memAddr, memWdata, memRdata = 16'hDEAD;

  logic        bCpuAck, bDmaReq = 0, bDmaAck, bMemVma, bMemRw, bBusy;
  logic [15:0] bCpuRdata, bDmaAddr = 0, bDmaRdata, bMemAddr, bMemWdata, bMemRdata = 16'hDEAD;

  mem_bus_arbiter #(.WIDTH(16), .WAIT_CYCLES(WAIT_A), .STARVE_LIMIT(3)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpuReq), .cpu_rw(cpuRw), .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata),
    .cpu_ack(cpuAck), .cpu_rdata(cpuRdata),
    .dma_req(dmaReq), .dma_rw(dmaRw), .dma_addr(dmaAddr), .dma_wdata(dmaWdata),
    .dma_ack(dmaAck), .dma_rdata(dmaRdata),
    .mem_vma(memVma), .mem_rw(memRw), .mem_addr(memAddr), .mem_wdata(memWdata),
    .mem_rdata(memRdata), .busy(busy)
  );

  mem_bus_arbiter #(.WIDTH(16), .WAIT_CYCLES(WAIT_B), .STARVE_LIMIT(3)) dutB (
    .clock(clock), .reset(reset),
    .cpu_req(1'b0), .cpu_rw(1'b0), .cpu_addr(16'h0), .cpu_wdata(16'h0),
    .cpu_ack(bCpuAck), .cpu_rdata(bCpuRdata),
    .dma_req(bDmaReq), .dma_rw(1'b0), .dma_addr(bDmaAddr), .dma_wdata(16'h0),
    .dma_ack(bDmaAck), .dma_rdata(bDmaRdata),
    .mem_vma(bMemVma), .mem_rw(bMemRw), .mem_addr(bMemAddr), .mem_wdata(bMemWdata),
    .mem_rdata(bMemRdata), .busy(bBusy)
  );

  int compared = 0;
  int mismatched = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] memVal(input logic [15:0] a);
    if (a == 16'h0010) return 16'hBEEF;
    return 16'(a * 16'd3) ^ 16'h5A5A;
  endfunction

  txn_t cpuQ[$], dmaQ[$];
  logic [15:0] bQ[$];
  logic grantLog[$];
  int cyc = 0;
  always @(posedge clock) cyc++;

  // Memory model + monitor for the default instance.
  int vmaCnt = 0, lastVmaStart = 0, lastAckCyc = 0;
  logic prevVma = 0, accRw = 0;
  logic [15:0] accAddr = 0, accWdata = 0, cpuHold = 0, dmaHold = 0;
  txn_t monE;
  always @(negedge clock) begin
    if (memVma) begin
      if (vmaCnt == 0) begin
        accRw = memRw; accAddr = memAddr; accWdata = memWdata; lastVmaStart = cyc;
      end else begin
        checkVal("mem_rw stable", 32'(memRw), 32'(accRw));
        checkVal("mem_addr stable", 32'(memAddr), 32'(accAddr));
        checkVal("mem_wdata stable", 32'(memWdata), 32'(accWdata));
      end
      memRdata = (vmaCnt == WAIT_A) ? memVal(memAddr) : 16'hDEAD;
      vmaCnt++;
    end else begin
      memRdata = 16'hDEAD;
    end
    if (cpuAck || dmaAck) begin
      checkVal("ack exclusive", 32'(cpuAck & dmaAck), 32'(0));
      checkVal("ack follows access", 32'(prevVma), 32'(1));
      checkVal("access length", 32'(vmaCnt), 32'(WAIT_A + 1));
      checkVal("pending request", dmaAck ? dmaQ.size() : cpuQ.size(), 32'(1));
      if ((dmaAck ? dmaQ.size() : cpuQ.size()) > 0) begin
        monE = dmaAck ? dmaQ.pop_front() : cpuQ.pop_front();
        checkVal("access rw", 32'(accRw), 32'(monE.rw));
        checkVal("access addr", 32'(accAddr), 32'(monE.addr));
        if (monE.rw) checkVal("access wdata", 32'(accWdata), 32'(monE.wdata));
        if (!monE.rw) begin
          if (dmaAck) dmaHold = monE.rdata; else cpuHold = monE.rdata;
        end
      end
      grantLog.push_back(dmaAck);
      lastAckCyc = cyc;
      vmaCnt = 0;
    end
    checkVal("cpu_rdata", 32'(cpuRdata), 32'(cpuHold));
    checkVal("dma_rdata", 32'(dmaRdata), 32'(dmaHold));
    checkVal("busy", 32'(busy), 32'(memVma | cpuAck | dmaAck));
    prevVma = memVma;
    if (reset) begin
      vmaCnt = 0; cpuHold = 0; dmaHold = 0; prevVma = 0;
    end
  end

  // Memory model for the WAIT_CYCLES=3 instance: data valid only in the 4th access cycle.
  int bVmaCnt = 0;
  always @(negedge clock) begin
    if (bMemVma) begin
      bMemRdata = (bVmaCnt == WAIT_B) ? memVal(bMemAddr) : 16'hDEAD;
      bVmaCnt++;
    end else begin
      bMemRdata = 16'hDEAD;
      bVmaCnt = 0;
    end
  end

  int reqCyc = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cpuXfer(input logic rw, input logic [15:0] a, input logic [15:0] wd, input bit keep);
    cpuQ.push_back('{rw: rw, addr: a, wdata: wd, rdata: memVal(a)});
    cpuReq = 1; cpuRw = rw; cpuAddr = a; cpuWdata = wd;
    reqCyc = cyc;
    for (int i = 0; i < 60 && !cpuAck; i++) tick();
    checkVal("cpu ack arrives", 32'(cpuAck), 32'(1));
    tick();
    if (!keep) cpuReq = 0;
  endtask

  task automatic dmaXfer(input logic rw, input logic [15:0] a, input logic [15:0] wd, input bit keep);
    dmaQ.push_back('{rw: rw, addr: a, wdata: wd, rdata: memVal(a)});
    dmaReq = 1; dmaRw = rw; dmaAddr = a; dmaWdata = wd;
    reqCyc = cyc;
    for (int i = 0; i < 60 && !dmaAck; i++) tick();
    checkVal("dma ack arrives", 32'(dmaAck), 32'(1));
    tick();
    if (!keep) dmaReq = 0;
  endtask

  initial begin #200000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

  initial begin
    int a1, a2, a3, startB, ackB, vmaB;
    logic [8:0] expOrder;

    repeat (2) tick();
    checkVal("reset vma/rw/busy", {29'd0, memVma, memRw, busy}, 32'd0);
    checkVal("reset acks", {30'd0, cpuAck, dmaAck}, 32'd0);
    checkVal("reset mem addr/wdata", {memAddr, memWdata}, 32'd0);
    checkVal("reset rdata", {cpuRdata, dmaRdata}, 32'd0);
    checkVal("reset B vma/busy", {30'd0, bMemVma, bBusy}, 32'd0);
    reset = 0;
    tick();

    // Single CPU read
    cpuXfer(1'b0, 16'h0010, 16'h0000, 1'b0);
    checkVal("cpu read vma start", 32'(lastVmaStart - reqCyc), 32'd1);
    checkVal("cpu read ack latency", 32'(lastAckCyc - reqCyc), 32'(WAIT_A + 2));
    checkVal("cpu read data", 32'(cpuRdata), 32'h0000BEEF);
    repeat (2) tick();

    // DMA write
    dmaXfer(1'b1, 16'h0200, 16'h1234, 1'b0);
    checkVal("dma write ack latency", 32'(lastAckCyc - reqCyc), 32'(WAIT_A + 2));
    checkVal("dma rdata after write", 32'(dmaRdata), 32'd0);
    checkVal("cpu rdata after dma", 32'(cpuRdata), 32'h0000BEEF);
    tick();

    // Back-to-back CPU requests
    cpuXfer(1'b0, 16'h0020, 16'h0, 1'b1); a1 = lastAckCyc;
    cpuXfer(1'b1, 16'h0021, 16'h5555, 1'b1); a2 = lastAckCyc;
    cpuXfer(1'b0, 16'h0022, 16'h0, 1'b0); a3 = lastAckCyc;
    checkVal("b2b spacing 1", 32'(a2 - a1), 32'd4);
    checkVal("b2b spacing 2", 32'(a3 - a2), 32'd4);
    tick();

    // Contention with anti-starvation
    grantLog.delete();
    fork
      begin
        for (int i = 0; i < 7; i++)
          cpuXfer(logic'(i % 2), 16'(16'h0100 + i), 16'(16'h7000 + i), i < 6);
      end
      begin
        dmaXfer(1'b0, 16'h0300, 16'h0000, 1'b1);
        dmaXfer(1'b1, 16'h0310, 16'hCAFE, 1'b0);
      end
    join
    expOrder = 9'b010001000;
    checkVal("grant count", grantLog.size(), 32'd9);
    for (int i = 0; i < 9 && i < grantLog.size(); i++)
      checkVal($sformatf("grant order %0d", i), 32'(grantLog[i]), 32'(expOrder[i]));
    tick();

    // Reset in the second access cycle of a CPU read
    cpuQ.push_back('{rw: 1'b0, addr: 16'h0030, wdata: 16'h0, rdata: memVal(16'h0030)});
    cpuReq = 1; cpuRw = 0; cpuAddr = 16'h0030; cpuWdata = 0;
    tick();
    tick();
    checkVal("pre-reset vma", 32'(memVma), 32'd1);
    reset = 1;
    tick();
    checkVal("abort vma/busy", {30'd0, memVma, busy}, 32'd0);
    checkVal("abort no ack", {30'd0, cpuAck, dmaAck}, 32'd0);
    checkVal("abort cpu_rdata", 32'(cpuRdata), 32'd0);
    checkVal("abort dma_rdata", 32'(dmaRdata), 32'd0);
    reset = 0;
    for (int i = 0; i < 60 && !cpuAck; i++) tick();
    checkVal("restart ack", 32'(cpuAck), 32'd1);
    checkVal("restart rdata", 32'(cpuRdata), 32'(memVal(16'h0030)));
    tick();
    cpuReq = 0;
    tick();

    // WAIT_CYCLES=3 instance: DMA read
    bQ.push_back(memVal(16'h0400));
    bDmaReq = 1; bDmaAddr = 16'h0400;
    startB = cyc; ackB = 0; vmaB = 0;
    for (int i = 0; i < 40 && !bDmaAck; i++) begin
      tick();
      if (bMemVma) vmaB++;
    end
    ackB = cyc;
    checkVal("B ack arrives", 32'(bDmaAck), 32'd1);
    checkVal("B vma cycles", 32'(vmaB), 32'(WAIT_B + 1));
    checkVal("B ack latency", 32'(ackB - startB), 32'(WAIT_B + 2));
    checkVal("B cpu idle", {15'd0, bCpuAck, bCpuRdata}, 32'd0);
    if (bQ.size() > 0) checkVal("B dma rdata", 32'(bDmaRdata), 32'(bQ.pop_front()));
    tick();
    bDmaReq = 0;
    repeat (3) tick();

    checkVal("cpu queue drained", cpuQ.size(), 32'd0);
    checkVal("dma queue drained", dmaQ.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
